// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a 2-flop input synchronizer, oversampling tick divider and valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse; otherwise parity_err is tied low.
module uart_rx_core #(
   parameter int C_CLOCKFREQ  = 12000000,
   parameter int C_BAUDRATE   = 9600,
   parameter int C_OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy,
   output logic       parity_err,
   output logic [2:0] dbg_state
);

   localparam int DIV_RAW = C_CLOCKFREQ / (C_BAUDRATE * C_OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW      = $clog2(C_OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [TW-1:0] OS_LAST  = TW'(C_OVERSAMPLE - 1);
   localparam logic [TW-1:0] OS_HALF  = TW'(C_OVERSAMPLE / 2 - 1);

   // Valid/ready: a byte transfers on a clk edge where valid & ready; data is stable while valid is high.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t          r_state, w_state_n;
   logic            r_sync1, r_sync2;
   logic [DW-1:0]   r_div_cnt;
   logic [TW-1:0]   r_tick_cnt, w_tick_n;
   logic [2:0]      r_bit_idx, w_bit_n;
   logic [7:0]      r_shift, w_shift_n;
   logic [7:0]      r_data;
   logic            r_valid, r_frame_err, r_overrun;
   logic            w_rxd_s, w_tick, w_start_det, w_stop_sample, w_par_bad, w_frame_ok;
`ifdef UART_RX_PARITY_EN
   logic            r_par, w_par_n;
   logic            r_parity_err;
`endif

   assign w_rxd_s     = r_sync2;
   assign w_tick      = (r_div_cnt == DIV_LAST);
   assign w_start_det = (r_state == S_IDLE) && !w_rxd_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   // Restarting on the start edge keeps every sample point at a fixed offset from the frame's falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_div_cnt <= '0;
      else if (w_start_det || w_tick)
         r_div_cnt <= '0;
      else
         r_div_cnt <= r_div_cnt + DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_n;
         r_tick_cnt <= w_tick_n;
         r_bit_idx  <= w_bit_n;
         r_shift    <= w_shift_n;
`ifdef UART_RX_PARITY_EN
         r_par      <= w_par_n;
`endif
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_tick_n      = r_tick_cnt;
      w_bit_n       = r_bit_idx;
      w_shift_n     = r_shift;
      w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_n       = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (!w_rxd_s) begin
               w_state_n = S_START;
               w_tick_n  = '0;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (r_tick_cnt == OS_HALF) begin
                  w_tick_n = '0;
                  w_bit_n  = '0;
                  w_state_n = w_rxd_s ? S_IDLE : S_DATA;
               end else begin
                  w_tick_n = r_tick_cnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_tick_cnt == OS_LAST) begin
                  w_tick_n  = '0;
                  w_shift_n = {w_rxd_s, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     w_state_n = S_PARITY;
`else
                     w_state_n = S_STOP;
`endif
                  end else begin
                     w_bit_n = r_bit_idx + 3'd1;
                  end
               end else begin
                  w_tick_n = r_tick_cnt + TW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               if (r_tick_cnt == OS_LAST) begin
                  w_tick_n  = '0;
                  w_par_n   = w_rxd_s;
                  w_state_n = S_STOP;
               end else begin
                  w_tick_n = r_tick_cnt + TW'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (w_tick) begin
               if (r_tick_cnt == OS_LAST) begin
                  w_tick_n      = '0;
                  w_stop_sample = 1'b1;
                  w_state_n     = w_rxd_s ? S_IDLE : S_BREAK;
               end else begin
                  w_tick_n = r_tick_cnt + TW'(1);
               end
            end
         end
         // A line held low after a bad stop bit must go high before another start is accepted.
         S_BREAK: begin
            if (w_rxd_s)
               w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign w_par_bad = ^{r_shift, r_par};
`else
   assign w_par_bad = 1'b0;
`endif
   assign w_frame_ok = w_stop_sample && w_rxd_s && !w_par_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= w_stop_sample && !w_rxd_s;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= w_stop_sample && w_par_bad;
`endif
         if (r_valid && ready)
            r_valid <= 1'b0;
         // A byte completing on the acceptance edge replaces the one being taken.
         if (w_frame_ok) begin
            if (!r_valid || ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed framing cases plus randomized bytes with random ready.
`timescale 1ns/1ps
module tb_uart_rx_core;

   localparam int CLK_HZ = 1920000;
   localparam int BAUD   = 9600;
   localparam int OS     = 16;
   localparam int DIV_M  = (CLK_HZ / (BAUD * OS) < 1) ? 1 : CLK_HZ / (BAUD * OS);
   localparam int BIT    = DIV_M * OS;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS  = 11;
`else
   localparam int NBITS  = 10;
`endif
   // First valid cycle: mid stop bit after the start edge, plus sync and detect cycles.
   localparam int LAT    = BIT * (2 * NBITS - 1) / 2 + 3;

   logic       clk = 1'b0;
   logic       reset, rxd, ready;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy, parity_err;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   int  fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, acc_cnt = 0, vh_cnt = 0;
   int  rise_cyc = -1;
   logic prev_valid = 1'b0;
   logic rand_ready = 1'b0;

   uart_rx_core #(
      .C_CLOCKFREQ (CLK_HZ),
      .C_BAUDRATE  (BAUD),
      .C_OVERSAMPLE(OS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy),
      .parity_err(parity_err),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (frame_err)  fe_cnt++;
         if (overrun)    ov_cnt++;
         if (parity_err) pe_cnt++;
         if (valid)      vh_cnt++;
         if (valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
         if (valid && ready) begin
            acc_cnt++;
            check_eq("byte_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("rx_byte", data, exp_q.pop_front());
         end
         prev_valid = valid;
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      rxd = b;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input int stop_low_bits);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip, BIT);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      if (stop_low_bits > 0) drive_bit(1'b0, stop_low_bits * BIT);
      else                   drive_bit(1'b1, BIT);
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_frame(b, 1'b0, 0);
   endtask

   initial begin
      int c0, n, exp_pe;
      logic [7:0] b;
      reset = 1'b1;
      rxd   = 1'b1;
      ready = 1'b0;
      exp_pe = 0;
      tick(5);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_data", data, 8'h00);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_flags", {frame_err, overrun, parity_err}, 3'b000);
      reset = 1'b0;
      tick(BIT);

      // single byte, latency and one-cycle valid with ready=1
      ready = 1'b1;
      c0 = cyc;
      send_good(8'h55);
      tick(4);
      check_eq("latency", rise_cyc - c0, LAT);
      check_eq("acc_55", acc_cnt, 1);
      check_eq("valid_width", vh_cnt, 1);
      check_eq("no_err_55", fe_cnt + ov_cnt, 0);

      // overrun: second byte dropped while first is held
      ready = 1'b0;
      send_good(8'hA3);
      send_frame(8'h0F, 1'b0, 0);
      tick(4);
      check_eq("ovr_pulse", ov_cnt, 1);
      check_eq("ovr_valid_held", valid, 1);
      check_eq("ovr_data_held", data, 8'hA3);
      check_eq("ovr_acc", acc_cnt, 1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(2);
      check_eq("ovr_valid_clear", valid, 0);
      check_eq("ovr_acc2", acc_cnt, 2);

      // short low glitch rejected
      ready = 1'b1;
      rxd = 1'b0;
      tick(BIT / 4);
      check_eq("glitch_busy", busy, 1);
      rxd = 1'b1;
      tick(BIT);
      check_eq("glitch_idle", busy, 0);
      check_eq("glitch_no_byte", acc_cnt, 2);
      check_eq("glitch_no_fe", fe_cnt, 0);

      // stop bit held low: single frame_err, stays busy until line returns high
      send_frame(8'h81, 1'b0, 3);
      check_eq("break_fe", fe_cnt, 1);
      check_eq("break_busy", busy, 1);
      check_eq("break_no_byte", acc_cnt, 2);
      rxd = 1'b1;
      tick(4);
      check_eq("break_exit", busy, 0);
      tick(BIT);
      send_good(8'h42);
      tick(4);
      check_eq("after_break_acc", acc_cnt, 3);

      // reset in the middle of a frame
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
      tick(BIT / 2);
      reset = 1'b1;
      tick(2);
      check_eq("mid_rst_valid", valid, 0);
      check_eq("mid_rst_data", data, 8'h00);
      check_eq("mid_rst_busy", busy, 0);
      reset = 1'b0;
      tick(BIT);
      send_good(8'h12);
      tick(4);
      check_eq("after_rst_acc", acc_cnt, 4);

`ifdef UART_RX_PARITY_EN
      send_good(8'h07);
      tick(4);
      check_eq("par_ok_acc", acc_cnt, 5);
      send_frame(8'h07, 1'b1, 0);
      tick(4);
      exp_pe = 1;
      check_eq("par_err_pulse", pe_cnt, 1);
      check_eq("par_err_no_byte", acc_cnt, 5);
      check_eq("par_err_valid", valid, 0);
`endif

      // random bytes, random gaps, random ready
      rand_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         send_good(b);
         tick($urandom_range(0, BIT));
      end
      rand_ready = 1'b0;
      ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * BIT) begin
         tick(1);
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
      check_eq("final_fe", fe_cnt, 1);
      check_eq("final_ov", ov_cnt, 1);
      check_eq("final_pe", pe_cnt, exp_pe);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Standalone UART receiver for the soc's serial console path: 8N1 frames on rxd, one byte per frame, presented on a valid/ready byte interface.
- Sits between the board RXD pin and the soc's memory-mapped UART register block.
- Fills the receive side; it pairs with the existing transmit path and uses the same C_CLOCKFREQ/C_BAUDRATE parameters passed down from top.

Parameters:
C_CLOCKFREQ, 12000000, input clock frequency in Hz
C_BAUDRATE, 9600, line rate in baud
C_OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4

Ports:
clk        input   1  system clock
reset      input   1  asynchronous, active-high reset
rxd        input   1  serial line, idle high, asynchronous to clk
data       output  8  received byte, valid while valid=1
valid      output  1  byte available
ready      input   1  consumer accepts byte on a clk edge where valid&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun    output  1  one-cycle pulse: byte completed while valid=1 and ready=0
busy       output  1  high when FSM is not IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; data=0, valid=0, frame_err=0, overrun=0, busy=0; both synchronizer flops=1.
- rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s; there is 2 cycles of input latency.
- Tick divider: DIV = C_CLOCKFREQ/(C_BAUDRATE*C_OVERSAMPLE), integer truncation, clamped to a minimum of 1. With defaults DIV=78, so one bit = 1248 clk.
  - Divider counter restarts at 0 on the start-edge detect, so tick phase is aligned to each frame.
- FSM:
  - IDLE: rxd_s==0 -> START, sample counter=0.
  - START: at tick C_OVERSAMPLE/2-1 (mid start bit), rxd_s==0 -> DATA, counter=0, bit index=0. rxd_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: every C_OVERSAMPLE ticks, sample rxd_s into the shift register, LSB first. After bit index 7 -> STOP.
  - STOP: at mid stop bit:
    - rxd_s==1 -> frame complete -> IDLE.
    - rxd_s==0 -> frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait for rxd_s==1 -> IDLE. Prevents a held-low line (break) from being read as repeated 0x00 frames.
- Output handshake:
  - On frame complete with valid==0: data<=byte, valid<=1 on the next edge.
  - valid stays high and data stays stable until a clk edge with ready=1; then valid<=0.
  - Frame complete on the same edge as acceptance (valid&ready): new byte loaded, valid stays 1, no overrun.
  - Frame complete with valid=1 and ready=0: new byte dropped, old data kept, overrun pulses for 1 cycle.
- Latency: valid rises 1 clk after the mid-stop sample tick, about 9.5 bit periods + 3 clk after the rxd falling edge.
- ready asserted while valid=0 has no effect.
- Reset mid-frame aborts the frame; no flags, valid=0 after reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state between DATA and STOP samples the 9th bit.
  - If XOR of data bits and parity bit == 1: parity_err output pulses 1 cycle at the stop sample and the byte is discarded (no valid, no overrun).
  - Framing check still applies. If both errors occur, both pulses fire in the same cycle.
- Undefined: no PARITY state, 8N1 framing. The parity_err port still exists, tied 0.

Test Plan:
- Defaults, send 0x55 at 9600 baud, ready=1 -> valid pulses 1 cycle with data=0x55; frame_err=0, overrun=0.
- Send 0xA3 then 0x0F back to back, ready=0 -> data=0xA3 held with valid=1; overrun pulses at the 0x0F stop sample. Then ready=1 for one edge -> valid=0.
- Drive rxd low for 300 clk (below the 624-clk half bit), then high -> FSM returns to IDLE, busy drops, no valid, no flags.
- Send frame 0x81 with stop bit held low for 3 bit times -> frame_err single pulse, no valid, FSM stays in BREAK until rxd=1. Then send 0x42 -> data=0x42 received.
- Assert reset during bit 4 of 0xFF, release, send 0x12 -> after reset valid=0 and data=0x00; 0x12 received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> data=0x07 valid. Send 0x07 with parity bit 0 -> parity_err pulse, no valid.
